// File: rtl/phase_sequencer_pkg.sv
// phase_pkg
// Shared phase encoding for the intersection sequencer and the helper that
// gives the fixed phase order. WALK is only inserted after RED2 when the
// cycle was started with a pedestrian request latched.
package phase_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        RED1        = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        RED2        = 3'd5,
        WALK        = 3'd6
    } phase_t;

    function automatic phase_t next_phase(input phase_t p, input logic ped_sel);
        case (p)
            MAIN_GREEN:  next_phase = MAIN_YELLOW;
            MAIN_YELLOW: next_phase = RED1;
            RED1:        next_phase = SIDE_GREEN;
            SIDE_GREEN:  next_phase = SIDE_YELLOW;
            SIDE_YELLOW: next_phase = RED2;
            RED2:        next_phase = ped_sel ? WALK : MAIN_GREEN;
            default:     next_phase = MAIN_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/phase_sequencer_traffic_comp_hyst.sv
// traffic_comp_hyst
// Decides which approach (if any) earns a green extension. One side must
// exceed the other by more than HYST; the two outputs are mutually exclusive.
// Ports:
//   main_level, side_level : latched traffic levels (TRAFFIC_W bits)
//   mGTs                   : main busier by more than HYST
//   mLTs                   : side busier by more than HYST
module traffic_comp_hyst #(
    parameter int TRAFFIC_W = 3,
    parameter int HYST      = 0
) (
    input  logic [TRAFFIC_W-1:0] main_level,
    input  logic [TRAFFIC_W-1:0] side_level,
    output logic                 mGTs,
    output logic                 mLTs
);
    // Two guard bits so level + margin cannot wrap.
    localparam int CW = TRAFFIC_W + 2;
    localparam logic [CW-1:0] HYST_C = CW'(HYST);

    logic [CW-1:0] main_x;
    logic [CW-1:0] side_x;

    assign main_x = CW'(main_level);
    assign side_x = CW'(side_level);

    assign mGTs = main_x > (side_x + HYST_C);
    assign mLTs = side_x > (main_x + HYST_C);

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer
// Tick-driven intersection phase sequencer. Owns the phase timer and the
// per-cycle tick counter; green times stretch for the busier approach and an
// optional pedestrian WALK phase is appended to the cycle.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   tick           : timebase strobe, timing advances only when high
//   ped_req        : pedestrian request (level or pulse)
//   main_traffic   : main-road level, sampled at cycle end only
//   side_traffic   : side-road level, sampled at cycle end only
//   enable         : one-clk pulse after every phase boundary
//   cycle_start    : one-clk pulse when a new cycle begins
//   phase          : current phase (phase_t encoding)
//   cycle_count    : ticks elapsed in current cycle, saturating
//   ped_pending    : pedestrian request latched and not yet served
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int TRAFFIC_W  = 3,
    parameter int HYST       = 0,
    parameter int BASE_GREEN = 10,
    parameter int EXT_GREEN  = 4,
    parameter int YELLOW     = 2,
    parameter int ALL_RED    = 2,
    parameter int WALK       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 ped_req,
    input  logic [TRAFFIC_W-1:0] main_traffic,
    input  logic [TRAFFIC_W-1:0] side_traffic,
    output logic                 enable,
    output logic                 cycle_start,
    output logic [2:0]           phase,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 ped_pending
);
    // Only one green can be extended, so the longest cycle has one extension.
    localparam int WORST = 2*BASE_GREEN + EXT_GREEN + 2*YELLOW + 2*ALL_RED + WALK;

    if (WORST > (2**CNT_W) - 1 || BASE_GREEN < 1 || YELLOW < 1 || ALL_RED < 1 || WALK < 1)
    begin : g_cfg_check
        $fatal(1, "phase_sequencer: durations invalid or cycle does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] BASE_C  = CNT_W'(BASE_GREEN);
    localparam logic [CNT_W-1:0] EXT_C   = CNT_W'(EXT_GREEN);
    localparam logic [CNT_W-1:0] YEL_C   = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] RED_C   = CNT_W'(ALL_RED);
    localparam logic [CNT_W-1:0] WALK_C  = CNT_W'(WALK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    phase_t                 state, state_n;
    logic [CNT_W-1:0]       timer, timer_n;
    logic [CNT_W-1:0]       cnt_n;
    logic [TRAFFIC_W-1:0]   main_q, main_n;
    logic [TRAFFIC_W-1:0]   side_q, side_n;
    logic                   ped_sel, ped_sel_n;
    logic                   pend_n, en_n, cs_n;
    logic                   mGTs, mLTs;
    logic [CNT_W-1:0]       dur;
    logic                   at_last, cycle_end;

    traffic_comp_hyst #(
        .TRAFFIC_W (TRAFFIC_W),
        .HYST      (HYST)
    ) u_comp (
        .main_level (main_q),
        .side_level (side_q),
        .mGTs       (mGTs),
        .mLTs       (mLTs)
    );

    // Duration of the current phase; driven only by latched traffic so the
    // running cycle never changes length.
    always_comb begin
        dur = WALK_C;
        case (state)
            MAIN_GREEN:               dur = mGTs ? BASE_C + EXT_C : BASE_C;
            SIDE_GREEN:               dur = mLTs ? BASE_C + EXT_C : BASE_C;
            MAIN_YELLOW, SIDE_YELLOW: dur = YEL_C;
            RED1, RED2:               dur = RED_C;
            default:                  dur = WALK_C;
        endcase
    end

    assign at_last   = (timer == dur - CNT_ONE);
    assign cycle_end = at_last && ((state == RED2 && !ped_sel) || state == phase_pkg::WALK);

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        cnt_n     = cycle_count;
        main_n    = main_q;
        side_n    = side_q;
        ped_sel_n = ped_sel;
        pend_n    = ped_pending;
        en_n      = 1'b0;
        cs_n      = 1'b0;
        if (tick) begin
            cnt_n = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_ONE;
            if (at_last) begin
                timer_n = '0;
                state_n = next_phase(state, ped_sel);
                en_n    = 1'b1;
                if (state_n == phase_pkg::WALK)
                    pend_n = 1'b0;
                if (cycle_end) begin
                    cnt_n     = '0;
                    cs_n      = 1'b1;
                    main_n    = main_traffic;
                    side_n    = side_traffic;
                    ped_sel_n = ped_pending | ped_req;
                end
            end else begin
                timer_n = timer + CNT_ONE;
            end
        end
        // A new request in the WALK-entry clock must survive the clear.
        if (ped_req)
            pend_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= MAIN_GREEN;
            timer       <= '0;
            cycle_count <= '0;
            main_q      <= '0;
            side_q      <= '0;
            ped_sel     <= 1'b0;
            ped_pending <= 1'b0;
            enable      <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            cycle_count <= cnt_n;
            main_q      <= main_n;
            side_q      <= side_n;
            ped_sel     <= ped_sel_n;
            ped_pending <= pend_n;
            enable      <= en_n;
            cycle_start <= cs_n;
        end
    end

    assign phase = state;

endmodule
